// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master controller.
// Frame layout: START bit, 3 command bits (path select + 2-bit op), 8 payload bits,
// optionally followed by turnaround and an 8-bit readback field.
package spi_master_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    CMD   = 3'd2,
    DATA  = 3'd3,
    TURN  = 3'd4,
    RDBK  = 3'd5,
    GAP   = 3'd6
  } state_t;

  localparam int CMD_BITS  = 3;
  localparam int DATA_BITS = 8;

  // Command field bit for position idx: path select (op[1]) is sent first,
  // then the op itself, MSB first.
  function automatic logic cmd_bit(input spi_op_t op, input logic [2:0] idx);
    logic [1:0] op_bits;
    op_bits = op;
    return (idx == 3'd2) ? op_bits[0] : op_bits[1];
  endfunction

endpackage

// File: rtl/spi_master_shreg.sv
// 8-bit shift register shared by the payload (shift-out, MSB first) and
// readback (shift-in at LSB) phases of an SPI frame.
module spi_master_shreg
  import spi_master_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 shift,
  input  logic                 shift_in,
  output logic [DATA_BITS-1:0] q
);

  // Load has priority over shift; shifting moves towards the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[DATA_BITS-2:0], shift_in};
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master. Serialises one command per handshake into a framed
// SPI transaction (SS_n/MOSI) and returns the byte read back on MISO for
// RD_DATA commands. The SPI bit clock is clk itself.
// Optional feature macro: SPI_MASTER_SEQ_CHK_EN -- rejects RD_DATA with
// rsp_err=1 (no frame sent) until an RD_ADDR frame has completed since reset.
//
// Handshake: a command is taken on the rising edge where cmd_valid && cmd_ready.
// cmd_op/cmd_data are captured on that edge. cmd_valid seen while cmd_ready=0 is
// ignored (no queueing); the host holds it until cmd_ready. rsp_valid is a
// one-cycle pulse with no back-pressure; rsp_data holds until the next pulse.
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int RD_TURN    = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] CMD_LAST  = 3'(CMD_BITS - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] TURN_LAST = 3'(RD_TURN - 1);
  // SS_n high cycles include the IDLE cycle in which the next command is
  // accepted, so the GAP state itself lasts GAP_CYCLES-1 cycles.
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 2);
  localparam state_t     EXIT_ST   = (GAP_CYCLES > 1) ? GAP : IDLE;

  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [3:0]             gap_q, gap_d;
  spi_op_t                op_q;
  logic                   skip_q;
  logic                   skip_now;
  logic                   accept;
  logic                   frame_d, mosi_d;
  logic                   rsp_fire_d, rsp_err_d;
  logic [DATA_BITS-1:0]   rsp_data_d;
  logic [DATA_BITS-1:0]   sh_q;
  logic                   ss_n_q, mosi_q, ready_q, busy_q;
  logic                   rsp_valid_q, rsp_err_q;
  logic [DATA_BITS-1:0]   rsp_data_q;

`ifdef SPI_MASTER_SEQ_CHK_EN
  logic rd_addr_set_q;

  // Sticky flag: a read address has been programmed since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_set_q <= 1'b0;
    end else if (state_q == DATA && cnt_q == DATA_LAST && op_q == RD_ADDR) begin
      rd_addr_set_q <= 1'b1;
    end
  end

  assign skip_now = (spi_op_t'(cmd_op) == RD_DATA) && !rd_addr_set_q;
`else
  assign skip_now = 1'b0;
`endif

  spi_master_shreg u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (cmd_data),
    .shift     ((state_q == DATA) || (state_q == RDBK)),
    .shift_in  ((state_q == RDBK) ? MISO : 1'b0),
    .q         (sh_q)
  );

  // Next-state and field counters; cnt wraps to 0 only on a state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        cnt_d = '0;
        gap_d = '0;
        state_d = skip_q ? EXIT_ST : CMD;
      end
      CMD: begin
        if (cnt_q == CMD_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DATA: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          gap_d   = '0;
          state_d = (op_q == RD_DATA) ? TURN : EXIT_ST;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      TURN: begin
        if (cnt_q == TURN_LAST) begin
          state_d = RDBK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RDBK: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          gap_d   = '0;
          state_d = EXIT_ST;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Values the registered outputs take in the next cycle.
  always_comb begin
    frame_d    = 1'b0;
    mosi_d     = 1'b0;
    rsp_fire_d = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = rsp_data_q;
    case (state_d)
      START:                frame_d = !skip_now;
      CMD, DATA, TURN, RDBK: frame_d = 1'b1;
      default:              frame_d = 1'b0;
    endcase
    case (state_d)
      CMD:  mosi_d = cmd_bit(op_q, cnt_d);
      // Entering DATA the MSB is still in place; inside DATA the register
      // shifts on the same edge, so the next bit is one position down.
      DATA: mosi_d = (state_q == DATA) ? sh_q[DATA_BITS-2] : sh_q[DATA_BITS-1];
      default: mosi_d = 1'b0;
    endcase
    if (state_q == RDBK && cnt_q == DATA_LAST) begin
      rsp_fire_d = 1'b1;
      rsp_data_d = {sh_q[DATA_BITS-2:0], MISO};
    end
    if (state_q == START && skip_q) begin
      rsp_fire_d = 1'b1;
      rsp_err_d  = 1'b1;
    end
  end

  // State, command capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      op_q        <= WR_ADDR;
      skip_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      if (accept) begin
        op_q   <= spi_op_t'(cmd_op);
        skip_q <= skip_now;
      end
      ss_n_q      <= !frame_d;
      mosi_q      <= mosi_d;
      ready_q     <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      rsp_valid_q <= rsp_fire_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign dbg_state = state_q;

endmodule
